ccff_chain_loader: RTL and testbench

- Configuration-chain controller for the IO/logic tile configuration flip-flop chain (ccff_head → ... → ccff_tail).
- Accepts bitstream words over a valid/ready handshake and serialises them onto ccff_head, pulsing a shift enable once per bit until exactly CHAIN_LEN bits are loaded.
- Sits between the bitstream source (JTAG/SPI front end) and the head of a tile's configuration chain; runs in the programming clock domain.

---
 rtl/ccff_chain_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ccff_chain_loader                                             |
// | Purpose  : Configuration-chain controller. Accepts bitstream words over  |
// |            a valid/ready handshake and serialises them LSB-first onto    |
// |            ccff_head, pulsing ccff_shift_en once per bit until exactly   |
// |            CHAIN_LEN bits have been loaded into the tile's chain.        |
// | Optional : CCFF_CHAIN_LOADER_READBACK_EN adds a recirculating readback   |
// |            pass (VERIFY) that compares the 1-bit population written on   |
// |            ccff_head with the population seen on ccff_tail.              |
// | Ports    : prog_clk      programming clock (rising edge)                 |
// |            pReset        synchronous active-high reset                   |
// |            start         begin a load (honoured in IDLE and DONE only)   |
// |            word_data     bitstream word, bit 0 shifted first             |
// |            word_valid    word_data valid                                 |
// |            word_ready    word accepted this cycle                        |
// |            ccff_head     serial data into chain head                     |
// |            ccff_shift_en chain shift enable                              |
// |            ccff_tail     serial data out of chain tail (readback only)   |
// |            busy          load/shift/verify in progress                   |
// |            done          level, high in DONE                             |
// |            bit_count     bits shifted in the current load (saturating)   |
// |            verify_err    readback population mismatch                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic              verify_err
);

    localparam int               WC_W        = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] c_CHAIN_LEN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [WC_W-1:0]  c_WORD_W    = WC_W'(WORD_W);
    localparam logic [WC_W-1:0]  c_WC_ONE    = WC_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_SHIFT  = 3'd2;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    localparam logic [2:0] c_ST_VERIFY = 3'd3;
`endif
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [WORD_W-1:0] r_sreg;
    logic [WC_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]  r_bit_count;
    logic [CNT_W-1:0]  w_bit_count_inc;
    logic              w_last_bit;
    logic              w_word_end;
    logic              w_start_load;
    logic              w_word_fire;

    // Saturating increment: the count never passes CHAIN_LEN, so a stray
    // extra cycle can never wrap it back to a small value.
    assign w_bit_count_inc = (r_bit_count == c_CHAIN_LEN) ? r_bit_count
                                                          : r_bit_count + c_CNT_ONE;
    // Evaluated during SHIFT: true when the bit leaving this cycle is the
    // final one of the chain (any unused upper word bits are dropped).
    assign w_last_bit   = (w_bit_count_inc == c_CHAIN_LEN);
    assign w_word_end   = ((r_word_cnt + c_WC_ONE) == c_WORD_W);
    assign w_start_load = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_word_fire  = (r_state == c_ST_LOAD) && word_valid;

    assign bit_count = r_bit_count;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [CNT_W-1:0] r_ones_in;
    logic [CNT_W-1:0] r_ones_out;
    logic [CNT_W-1:0] r_verify_cnt;
    logic [CNT_W-1:0] w_ones_out_final;
    logic             r_verify_err;
    logic             w_verify_last;

    assign w_verify_last    = ((r_verify_cnt + c_CNT_ONE) == c_CHAIN_LEN);
    // Include the bit on ccff_tail in the final VERIFY cycle.
    assign w_ones_out_final = ccff_tail ? (r_ones_out + c_CNT_ONE) : r_ones_out;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and outputs. Every output is decoded from the current
    // state so reset (IDLE) deasserts them all on the same edge.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        word_ready    = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid) begin
                    w_state_next = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = r_sreg[0];
                busy          = 1'b1;
                if (w_last_bit) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
                    w_state_next = c_ST_VERIFY;
`else
                    w_state_next = c_ST_DONE;
`endif
                end else if (w_word_end) begin
                    w_state_next = c_ST_LOAD;
                end
            end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            c_ST_VERIFY: begin
                // Feed the tail back into the head: after CHAIN_LEN shifts
                // the chain holds exactly what it held before the pass.
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                busy          = 1'b1;
                if (w_verify_last) begin
                    w_state_next = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Shift register, in-word counter and chain bit counter
    // ---------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_sreg      <= '0;
            r_word_cnt  <= '0;
            r_bit_count <= '0;
        end else begin
            if (w_start_load) begin
                r_bit_count <= '0;
            end
            if (w_word_fire) begin
                r_sreg     <= word_data;
                r_word_cnt <= '0;
            end
            if (r_state == c_ST_SHIFT) begin
                r_sreg      <= r_sreg >> 1;
                r_word_cnt  <= r_word_cnt + c_WC_ONE;
                r_bit_count <= w_bit_count_inc;
            end
        end
    end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    // ---------------------------------------------------------------------
    // Readback: population count of written bits versus bits seen at the
    // tail during one full recirculation of the chain.
    // ---------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_ones_in    <= '0;
            r_ones_out   <= '0;
            r_verify_cnt <= '0;
            r_verify_err <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_ones_in    <= '0;
                r_ones_out   <= '0;
                r_verify_cnt <= '0;
                r_verify_err <= 1'b0;
            end
            if ((r_state == c_ST_SHIFT) && r_sreg[0]) begin
                r_ones_in <= r_ones_in + c_CNT_ONE;
            end
            if (r_state == c_ST_VERIFY) begin
                r_verify_cnt <= r_verify_cnt + c_CNT_ONE;
                r_ones_out   <= w_ones_out_final;
                if (w_verify_last) begin
                    r_verify_err <= (r_ones_in != w_ones_out_final);
                end
            end
        end
    end

    assign verify_err = r_verify_err;
`else
    // The tail is only observed by the readback pass.
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign verify_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ccff_chain_loader                                          |
// | Purpose  : Self-checking bench for ccff_chain_loader (CHAIN_LEN=10,      |
// |            WORD_W=4) with a 10-flop chain model on ccff_head/ccff_tail.  |
// |            Honours CCFF_CHAIN_LOADER_READBACK_EN when defined.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ccff_chain_loader;

    localparam int CL = 10;
    localparam int WW = 4;
    localparam int CW = $clog2(CL + 1);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    localparam int SHIFTS_PER_LOAD = 2 * CL;
`else
    localparam int SHIFTS_PER_LOAD = CL;
`endif
    localparam logic [CL-1:0] c_SEQ   = 10'b1101011010; // bit i = i-th bit shifted
    localparam logic [CL-1:0] c_CHAIN = 10'b0101101011; // chain[9] = first bit
    localparam int STUCK_IDX = 8;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b1;
    logic          start    = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_count;
    logic          verify_err;

    int n_checks = 0;
    int n_pass   = 0;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count),
        .verify_err   (verify_err)
    );

    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Chain of CL flops; optional stuck-at-0 flop
    // ---------------------------------------------------------------------
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] chain_nxt;
    logic          stuck_en = 1'b0;
    assign ccff_tail = chain[CL-1];

    always @(posedge prog_clk) begin
        if (ccff_shift_en === 1'b1) begin
            chain_nxt = {chain[CL-2:0], ccff_head};
            if (stuck_en) chain_nxt[STUCK_IDX] = 1'b0;
            chain <= chain_nxt;
        end
    end

    // Serial history of every bit driven while shift_en is high
    logic hist [0:1023];
    int   cap_total = 0;
    always @(negedge prog_clk) begin
        if (ccff_shift_en === 1'b1) begin
            hist[cap_total] = ccff_head;
            cap_total++;
        end
    end

    // ---------------------------------------------------------------------
    // Transaction-level model: tracks accepted words, bits shifted so far
    // and readback progress; derives the expected outputs from those.
    // Checks at negedge, then predicts the effect of the coming edge.
    // ---------------------------------------------------------------------
    logic m_valid = 1'b0, m_active = 1'b0, m_done = 1'b0, m_verify = 1'b0, m_err = 1'b0;
    int   m_cnt = 0, m_words = 0, m_vcnt = 0, m_vones = 0, m_pc;
    logic m_bits [0:CL+WW-1];
    logic e_ready, e_shift, e_head;

    always @(negedge prog_clk) begin
        e_ready = 1'b0;
        e_shift = 1'b0;
        e_head  = 1'b0;
        if (m_active && !m_verify) begin
            e_ready = (m_cnt == m_words * WW);
            e_shift = (m_cnt <  m_words * WW);
            e_head  = e_shift ? m_bits[m_cnt] : 1'b0;
        end else if (m_verify) begin
            e_shift = 1'b1;
            e_head  = ccff_tail;
        end
        if (m_valid) begin
            check("word_ready", 32'(word_ready),    32'(e_ready));
            check("shift_en",   32'(ccff_shift_en), 32'(e_shift));
            check("ccff_head",  32'(ccff_head),     32'(e_head));
            check("busy",       32'(busy),          32'(m_active));
            check("done",       32'(done),          32'(m_done));
            check("bit_count",  32'(bit_count),     m_cnt);
            check("verify_err", 32'(verify_err),    32'(m_err));
        end
        if (pReset) begin
            m_valid = 1'b1; m_active = 1'b0; m_done = 1'b0; m_verify = 1'b0;
            m_err = 1'b0; m_cnt = 0; m_words = 0;
        end else if (m_valid) begin
            if (!m_active && start) begin
                m_active = 1'b1; m_done = 1'b0; m_verify = 1'b0; m_err = 1'b0;
                m_cnt = 0; m_words = 0; m_vcnt = 0; m_vones = 0;
            end else if (m_active && !m_verify) begin
                if (e_ready && word_valid) begin
                    for (int k = 0; k < WW; k++) m_bits[m_words * WW + k] = word_data[k];
                    m_words++;
                end
                if (e_shift) begin
                    m_cnt++;
                    if (m_cnt == CL) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
                        m_verify = 1'b1; m_vcnt = 0; m_vones = 0;
`else
                        m_active = 1'b0; m_done = 1'b1;
`endif
                    end
                end
            end else if (m_verify) begin
                if (ccff_tail) m_vones++;
                m_vcnt++;
                if (m_vcnt == CL) begin
                    m_pc = 0;
                    for (int i = 0; i < CL; i++) if (m_bits[i]) m_pc++;
                    m_err = (m_pc != m_vones);
                    m_verify = 1'b0; m_active = 1'b0; m_done = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // ---------------------------------------------------------------------
    int base = 0;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        base = cap_total;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int gap);
        int guard;
        if (gap > 0) begin
            word_valid = 1'b0;
            guard = 0;
            while (word_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
            if (guard >= 50) check("gap_ready_timeout", 32'(0), 32'(1));
            for (int g = 0; g < gap; g++) begin
                check("gap_ready", 32'(word_ready),    32'(1));
                check("gap_shift", 32'(ccff_shift_en), 32'(0));
                tick();
            end
        end
        word_valid = 1'b1;
        word_data  = w;
        guard = 0;
        while (word_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
        if (guard >= 50) check("word_ready_timeout", 32'(0), 32'(1));
        tick();
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin tick(); guard++; end
        if (guard >= 100) check("done_timeout", 32'(0), 32'(1));
        word_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic exp_err);
        logic [CL-1:0] seq;
        for (int i = 0; i < CL; i++) seq[i] = hist[base + i];
        check({tag, "_done"},      32'(done),        32'(1));
        check({tag, "_bit_count"}, 32'(bit_count),   32'(CL));
        check({tag, "_shifts"},    cap_total - base, SHIFTS_PER_LOAD);
        check({tag, "_serial"},    32'(seq),         32'(c_SEQ));
        check({tag, "_verify_err"},32'(verify_err),  32'(exp_err));
        if (!exp_err) check({tag, "_chain"}, 32'(chain), 32'(c_CHAIN));
    endtask

    task automatic full_load(input int gap2, input logic glitch);
        start_load();
        send_word(4'hA, 0);
        if (glitch) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        send_word(4'h5, gap2);
        send_word(4'h3, 0);
        wait_done();
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        int guard;
        pReset = 1'b1;
        repeat (3) tick();
        pReset = 1'b0;
        check("rst_busy",       32'(busy),          32'(0));
        check("rst_done",       32'(done),          32'(0));
        check("rst_ready",      32'(word_ready),    32'(0));
        check("rst_shift",      32'(ccff_shift_en), 32'(0));
        check("rst_head",       32'(ccff_head),     32'(0));
        check("rst_bit_count",  32'(bit_count),     32'(0));
        check("rst_verify_err", 32'(verify_err),    32'(0));
        repeat (2) tick();

        // Words presented back to back with valid held high
        full_load(0, 1'b0);
        check_result("t1", 1'b0);

        // Stall of 5 cycles before the second word
        full_load(5, 1'b0);
        check_result("t2", 1'b0);

        // Reset in the middle of the second word
        start_load();
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        guard = 0;
        while ((cap_total - base) < 6 && guard < 50) begin tick(); guard++; end
        if (guard >= 50) check("t3_shift_timeout", 32'(0), 32'(1));
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        word_valid = 1'b0;
        check("t3_busy",      32'(busy),          32'(0));
        check("t3_shift",     32'(ccff_shift_en), 32'(0));
        check("t3_bit_count", 32'(bit_count),     32'(0));
        check("t3_ready",     32'(word_ready),    32'(0));
        tick();
        full_load(0, 1'b0);
        check_result("t3", 1'b0);

        // start during SHIFT is ignored; start in DONE reloads
        full_load(0, 1'b1);
        check_result("t4a", 1'b0);
        start_load();
        check("t4_reload_bit_count", 32'(bit_count),  32'(0));
        check("t4_reload_ready",     32'(word_ready), 32'(1));
        check("t4_reload_done",      32'(done),       32'(0));
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        send_word(4'h3, 0);
        wait_done();
        check_result("t4b", 1'b0);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        // Stuck-at-0 flop in the chain must be flagged
        stuck_en = 1'b1;
        full_load(0, 1'b0);
        check_result("t5_stuck", 1'b1);
        stuck_en = 1'b0;
        full_load(0, 1'b0);
        check_result("t5_clean", 1'b0);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
